leve_pcgen: RTL

Program-counter generator for the LEVE front end; it sits directly upstream of the instruction burst buffer and drives its PC handshake. Produces a sequential word-aligned fetch address stream from a boot vector and accepts redirects (branch/jump/trap targets) through a handshake port. It also provides:
- an epoch bit, so decode can squash instructions fetched before a redirect;
- a sticky fault on misaligned redirect targets.

---
 rtl/leve_pkg.sv | 13 +
 rtl/leve_pcgen.sv | 81 ++++++++
 2 files changed

// File: rtl/leve_pkg.sv
// Shared LEVE front-end definitions: PC-generator state encoding and fetch constants.
package leve_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } pcgen_st_t;

    localparam logic [31:0] LEVE_BOOT_ADDR  = 32'h8000_0000;
    localparam logic [31:0] LEVE_INST_BYTES = 32'd4;

endpackage

// File: rtl/leve_pcgen.sv
// LEVE program-counter generator: sequential word-aligned fetch stream with
// redirect handshake, epoch tracking and sticky misaligned-target fault.
module leve_pcgen
    import leve_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = LEVE_BOOT_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_pc_valid,
    output logic [31:0] o_pc_pc,
    input  logic        i_pc_ready,
    input  logic        i_rdir_valid,
    input  logic [31:0] i_rdir_payload,
    output logic        o_rdir_ready,
    input  logic        i_halt,
    output logic        o_epoch,
    output logic        o_fault,
    output logic [31:0] o_fault_addr,
    output logic [31:0] o_fetch_cnt
);

    pcgen_st_t   r_st;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_fault_addr;
    logic        r_epoch;
    logic        r_fault;

    logic        w_fire;
    logic        w_accept;
    logic        w_aligned;

    always_comb begin
        o_pc_valid   = (r_st == ST_RUN) && !i_halt;
        o_rdir_ready = (r_st == ST_RUN);
        w_fire       = o_pc_valid && i_pc_ready;
        w_accept     = i_rdir_valid && o_rdir_ready;
        w_aligned    = (i_rdir_payload[1:0] == 2'b00);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st         <= ST_BOOT;
            r_pc         <= BOOT_ADDR;
            r_fetch_cnt  <= '0;
            r_fault_addr <= '0;
            r_epoch      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_st)
                ST_BOOT: r_st <= ST_RUN;
                ST_RUN: begin
                    if (w_fire) begin
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                    end
                    // A redirect overrides the sequential +4; a misaligned one freezes pc.
                    if (w_accept && !w_aligned) begin
                        r_fault      <= 1'b1;
                        r_fault_addr <= i_rdir_payload;
                        r_st         <= ST_FAULT;
                    end else if (w_accept) begin
                        r_pc    <= i_rdir_payload;
                        r_epoch <= ~r_epoch;
                    end else if (w_fire) begin
                        r_pc <= r_pc + LEVE_INST_BYTES;
                    end
                end
                ST_FAULT: r_st <= ST_FAULT;
                default:  r_st <= ST_BOOT;
            endcase
        end
    end

    assign o_pc_pc      = r_pc;
    assign o_epoch      = r_epoch;
    assign o_fault      = r_fault;
    assign o_fault_addr = r_fault_addr;
    assign o_fetch_cnt  = r_fetch_cnt;

endmodule
